// File: rtl/fcs_pkg.sv
// -----------------------------------------------------------------------------
// fcs_pkg
// Shared definitions for the serial CRC-16 FCS path (TX sequencer and RX checker).
//   CRC16_POLY    : generator polynomial, x^16 term implicit
//   CRC16_INIT    : CRC value loaded at the start of each frame
//   CRC16_RESIDUE : remainder left by a frame that includes its own FCS
//   fcs_state_e   : TX sequencer states
//   crc16_step()  : advance the CRC by one bit, MSB-first, no reflection
// -----------------------------------------------------------------------------
package fcs_pkg;

  localparam logic [15:0] CRC16_POLY    = 16'h1021;
  localparam logic [15:0] CRC16_INIT    = 16'h0000;
  localparam logic [15:0] CRC16_RESIDUE = 16'h0000;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    WAIT,
    FCS
  } fcs_state_e;

  // One bit of a shift-left CRC. The feedback is the outgoing MSB XOR the new bit.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc,
                                             input logic        din,
                                             input logic [15:0] poly = CRC16_POLY);
    logic fb;
    fb = crc[15] ^ din;
    return {crc[14:0], 1'b0} ^ (fb ? poly : 16'h0000);
  endfunction

endpackage

// File: rtl/fcs_bit_serializer.sv
// -----------------------------------------------------------------------------
// fcs_bit_serializer
// Load-and-shift register that presents its MSB as the serial bit. It holds
// either a byte (left-justified in the upper 8 bits) or a full 16-bit word.
//   clk, rst      : clock, synchronous active-high reset
//   i_load        : load i_load_data, index restarts at 0 (wins over i_shift)
//   i_load_wide   : 1 = 16-bit word, 0 = byte in i_load_data[15:8]
//   i_load_data   : value to load
//   i_shift       : current bit consumed, advance to the next one
//   o_bit         : bit currently presented (register MSB)
//   o_last        : presented bit is the final one of the loaded word
// -----------------------------------------------------------------------------
module fcs_bit_serializer (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic        i_load_wide,
  input  logic [15:0] i_load_data,
  input  logic        i_shift,
  output logic        o_bit,
  output logic        o_last
);

  logic [15:0] r_sh;
  logic [3:0]  r_idx;
  logic        r_wide;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order; reset is sampled
  // synchronously inside the clocked block.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sh   <= 16'h0000;
      r_idx  <= 4'd0;
      r_wide <= 1'b0;
    end else if (i_load) begin
      r_sh   <= i_load_data;
      r_idx  <= 4'd0;
      r_wide <= i_load_wide;
    end else if (i_shift) begin
      r_sh   <= {r_sh[14:0], 1'b0};
      r_idx  <= r_idx + 4'd1;
    end
  end

  assign o_bit  = r_sh[15];
  assign o_last = r_wide ? (r_idx == 4'd15) : (r_idx == 4'd7);

endmodule

// File: rtl/fcs_tx_ctrl.sv
// -----------------------------------------------------------------------------
// fcs_tx_ctrl
// Transmit frame sequencer: accepts bytes over valid/ready, shifts them out
// MSB-first one bit per bit_en, runs CRC-16 over the data bits and appends the
// 16-bit FCS MSB-first.
//   clk, rst, clr         : clock, synchronous reset, synchronous frame abort
//   s_data/s_valid/s_last : byte input, accepted when s_valid & s_ready
//   s_ready               : byte can be accepted this cycle
//   bit_en                : downstream consumes bit_o this cycle
//   bit_o/bit_valid       : serial data/FCS bit and its qualifier
//   bit_last              : bit_o is the final FCS bit
//   fcs_o                 : FCS of the last completed frame
//   frame_done            : one-cycle pulse after the final FCS bit is consumed
//   byte_cnt              : bytes accepted in current/last frame, saturating
// -----------------------------------------------------------------------------
module fcs_tx_ctrl
  import fcs_pkg::*;
#(
  parameter logic [15:0] POLY  = CRC16_POLY,
  parameter logic [15:0] INIT  = CRC16_INIT,
  parameter int          CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [7:0]       s_data,
  input  logic             s_valid,
  input  logic             s_last,
  output logic             s_ready,
  input  logic             bit_en,
  output logic             bit_o,
  output logic             bit_valid,
  output logic             bit_last,
  output logic [15:0]      fcs_o,
  output logic             frame_done,
  output logic [CNT_W-1:0] byte_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  fcs_state_e       r_state;
  logic [15:0]      r_crc;
  logic             r_last;
  logic [15:0]      r_fcs;
  logic             r_frame_done;
  logic [CNT_W-1:0] r_byte_cnt;

  logic             w_ser_bit;
  logic             w_ser_last;
  logic             w_consume;
  logic             w_byte_end;
  logic             w_accept;
  logic             w_snap;
  logic             w_load;
  logic [15:0]      w_load_data;
  logic [15:0]      w_crc_next;
  logic [CNT_W-1:0] w_cnt_inc;

  assign bit_valid  = (r_state == DATA) || (r_state == FCS);
  assign bit_o      = bit_valid & w_ser_bit;
  assign bit_last   = (r_state == FCS) & w_ser_last;
  assign w_consume  = bit_valid & bit_en;
  assign w_byte_end = (r_state == DATA) & w_consume & w_ser_last;

  // Mid-frame ready opens only as the last data bit of a non-final byte is
  // consumed, so the next byte follows with no bubble. A byte offered with
  // rst or clr is never handshaken.
  assign s_ready  = !rst && !clr &&
                    ((r_state == IDLE) || (r_state == WAIT) || (w_byte_end && !r_last));
  assign w_accept = s_valid & s_ready;

  assign w_crc_next = crc16_step(r_crc, w_ser_bit, POLY);

  // The FCS snapshot must include the final data bit, hence w_crc_next.
  assign w_snap      = w_byte_end & r_last & !clr;
  assign w_load      = w_accept | w_snap;
  assign w_load_data = w_accept ? {s_data, 8'h00} : w_crc_next;

  assign w_cnt_inc = (r_byte_cnt == {CNT_W{1'b1}}) ? r_byte_cnt : r_byte_cnt + CNT_ONE;

  fcs_bit_serializer u_ser (
    .clk         (clk),
    .rst         (rst),
    .i_load      (w_load),
    .i_load_wide (!w_accept),
    .i_load_data (w_load_data),
    .i_shift     (w_consume),
    .o_bit       (w_ser_bit),
    .o_last      (w_ser_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_crc        <= INIT;
      r_last       <= 1'b0;
      r_fcs        <= 16'h0000;
      r_frame_done <= 1'b0;
      r_byte_cnt   <= '0;
    end else begin
      r_frame_done <= 1'b0;
      if (clr) begin
        r_state <= IDLE;
        r_crc   <= INIT;
      end else begin
        unique case (r_state)
          IDLE: begin
            if (w_accept) begin
              r_state    <= DATA;
              r_crc      <= INIT;
              r_last     <= s_last;
              r_byte_cnt <= CNT_ONE;
            end
          end
          DATA: begin
            if (w_consume) begin
              r_crc <= w_crc_next;
              if (w_ser_last) begin
                if (r_last) begin
                  r_state <= FCS;
                end else if (w_accept) begin
                  r_last     <= s_last;
                  r_byte_cnt <= w_cnt_inc;
                end else begin
                  r_state <= WAIT;
                end
              end
            end
          end
          WAIT: begin
            if (w_accept) begin
              r_state    <= DATA;
              r_last     <= s_last;
              r_byte_cnt <= w_cnt_inc;
            end
          end
          FCS: begin
            // r_crc is frozen here and equals the value loaded into the serializer.
            if (w_consume && w_ser_last) begin
              r_state      <= IDLE;
              r_fcs        <= r_crc;
              r_frame_done <= 1'b1;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign fcs_o      = r_fcs;
  assign frame_done = r_frame_done;
  assign byte_cnt   = r_byte_cnt;

endmodule

// File: tb/tb_fcs_tx_ctrl.sv
module tb_fcs_tx_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_last;
  logic        s_ready;
  logic        bit_en;
  logic        bit_o;
  logic        bit_valid;
  logic        bit_last;
  logic [15:0] fcs_o;
  logic        frame_done;
  logic [15:0] byte_cnt;

  int errors = 0;
  int checks = 0;

  logic [7:0] frame_buf [16];

  always #5 clk = ~clk;

  fcs_tx_ctrl #(
    .POLY  (16'h1021),
    .INIT  (16'h0000),
    .CNT_W (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_last     (s_last),
    .s_ready    (s_ready),
    .bit_en     (bit_en),
    .bit_o      (bit_o),
    .bit_valid  (bit_valid),
    .bit_last   (bit_last),
    .fcs_o      (fcs_o),
    .frame_done (frame_done),
    .byte_cnt   (byte_cnt)
  );

  task automatic set_digits();
    for (int i = 0; i < 9; i++) frame_buf[i] = 8'h31 + 8'(i);
  endtask

  // Drives one frame of n bytes from frame_buf and checks the serial stream
  // against the bytes followed by exp_fcs. Must be called at a negedge.
  task automatic run_frame(input string name, input int n, input int en_pct,
                           input int gap_pct, input logic [15:0] exp_fcs,
                           input bit hold_next, input logic [7:0] hold_data);
    int   idx, total, cycles, bad_last, unstable, hold_bad, mism, first_mism;
    logic cap[$];
    logic exp_bit, prev_hold, prev_bit, ready_at_done;
    bit   done_seen;
    total = 8*n + 16;
    idx = 0; cycles = 0; bad_last = 0; unstable = 0; hold_bad = 0;
    mism = 0; first_mism = -1; prev_hold = 1'b0; prev_bit = 1'b0;
    done_seen = 1'b0; ready_at_done = 1'b0;
    while (cycles < 5000) begin
      if (frame_done === 1'b1 && cap.size() > 0) begin
        done_seen = 1'b1;
        ready_at_done = s_ready;
        break;
      end
      bit_en = ($urandom_range(99) < en_pct);
      if (idx < n) begin
        s_valid = ($urandom_range(99) >= gap_pct);
        s_data  = frame_buf[idx];
        s_last  = (idx == n-1);
      end else if (hold_next) begin
        s_valid = 1'b1; s_data = hold_data; s_last = 1'b1;
      end else begin
        s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0;
      end
      #1;
      if (prev_hold && (bit_valid !== 1'b1 || bit_o !== prev_bit)) unstable++;
      if (idx >= n && hold_next && s_ready !== 1'b0) hold_bad++;
      if (s_valid && s_ready === 1'b1 && idx < n) idx++;
      if (bit_valid === 1'b1 && bit_en) begin
        cap.push_back(bit_o);
        if (bit_last !== (cap.size() == total)) bad_last++;
      end
      prev_hold = (bit_valid === 1'b1) && !bit_en;
      prev_bit  = bit_o;
      @(negedge clk);
      cycles++;
    end
    checks++;
    if (!done_seen) begin
      errors++; $display("FAIL %s_done: frame_done not seen after %0d cycles", name, cycles);
    end
    checks++;
    if (cap.size() != total) begin
      errors++; $display("FAIL %s_nbits: got %0d bits expected %0d", name, cap.size(), total);
    end
    for (int k = 0; k < cap.size() && k < total; k++) begin
      exp_bit = (k < 8*n) ? frame_buf[k/8][7 - (k%8)] : exp_fcs[15 - (k - 8*n)];
      if (cap[k] !== exp_bit) begin
        mism++;
        if (first_mism < 0) first_mism = k;
      end
    end
    checks++;
    if (mism != 0) begin
      errors++; $display("FAIL %s_stream: %0d wrong bits, first at %0d, expected 0 wrong", name, mism, first_mism);
    end
    checks++;
    if (bad_last != 0) begin
      errors++; $display("FAIL %s_bit_last: %0d misplaced, expected only on bit %0d", name, bad_last, total);
    end
    checks++;
    if (unstable != 0) begin
      errors++; $display("FAIL %s_stable: %0d changes while stalled, expected 0", name, unstable);
    end
    checks++;
    if (fcs_o !== exp_fcs) begin
      errors++; $display("FAIL %s_fcs: got %h expected %h", name, fcs_o, exp_fcs);
    end
    checks++;
    if (byte_cnt !== 16'(n)) begin
      errors++; $display("FAIL %s_byte_cnt: got %0d expected %0d", name, byte_cnt, n);
    end
    if (hold_next) begin
      checks++;
      if (hold_bad != 0) begin
        errors++; $display("FAIL %s_ready_hold: s_ready high %0d times before IDLE, expected 0", name, hold_bad);
      end
      checks++;
      if (ready_at_done !== 1'b1) begin
        errors++; $display("FAIL %s_ready_idle: got %b expected 1", name, ready_at_done);
      end
    end
  endtask

  task automatic check_idle_outputs(input string name, input logic [15:0] exp_fcs,
                                    input logic [15:0] exp_cnt);
    checks++;
    if (s_ready !== 1'b1) begin errors++; $display("FAIL %s_s_ready: got %b expected 1", name, s_ready); end
    checks++;
    if (bit_valid !== 1'b0) begin errors++; $display("FAIL %s_bit_valid: got %b expected 0", name, bit_valid); end
    checks++;
    if (bit_last !== 1'b0) begin errors++; $display("FAIL %s_bit_last: got %b expected 0", name, bit_last); end
    checks++;
    if (bit_o !== 1'b0) begin errors++; $display("FAIL %s_bit_o: got %b expected 0", name, bit_o); end
    checks++;
    if (frame_done !== 1'b0) begin errors++; $display("FAIL %s_frame_done: got %b expected 0", name, frame_done); end
    checks++;
    if (fcs_o !== exp_fcs) begin errors++; $display("FAIL %s_fcs: got %h expected %h", name, fcs_o, exp_fcs); end
    checks++;
    if (byte_cnt !== exp_cnt) begin errors++; $display("FAIL %s_byte_cnt: got %0d expected %0d", name, byte_cnt, exp_cnt); end
  endtask

  task automatic test_reset();
    #1;
    check_idle_outputs("reset", 16'h0000, 16'd0);
  endtask

  task automatic test_check_string();
    set_digits();
    run_frame("str_full", 9, 100, 0, 16'h31C3, 1'b0, 8'h00);
  endtask

  task automatic test_single_bytes();
    frame_buf[0] = 8'h01;
    run_frame("byte01", 1, 100, 0, 16'h1021, 1'b0, 8'h00);
    frame_buf[0] = 8'hFF;
    run_frame("byteFF", 1, 100, 0, 16'h1EF0, 1'b0, 8'h00);
    frame_buf[0] = 8'h00;
    run_frame("byte00", 1, 100, 0, 16'h0000, 1'b0, 8'h00);
  endtask

  task automatic test_random_en();
    set_digits();
    run_frame("str_rand", 9, 30, 50, 16'h31C3, 1'b0, 8'h00);
  endtask

  task automatic test_back_to_back();
    set_digits();
    run_frame("b2b_first", 9, 100, 0, 16'h31C3, 1'b1, 8'hFF);
    frame_buf[0] = 8'hFF;
    run_frame("b2b_second", 1, 100, 0, 16'h1EF0, 1'b0, 8'h00);
  endtask

  task automatic test_clr();
    int idx, cycles, bad;
    set_digits();
    idx = 0; cycles = 0; bad = 0;
    bit_en = 1'b1;
    while (idx < 3 && cycles < 500) begin
      s_valid = 1'b1; s_data = frame_buf[idx]; s_last = 1'b0;
      #1;
      if (s_ready === 1'b1) idx++;
      @(negedge clk);
      cycles++;
    end
    checks++;
    if (idx != 3) begin errors++; $display("FAIL clr_setup: accepted %0d bytes expected 3", idx); end
    clr = 1'b1; s_valid = 1'b1; s_data = frame_buf[3];
    #1;
    checks++;
    if (s_ready !== 1'b0) begin errors++; $display("FAIL clr_ready: got %b expected 0", s_ready); end
    @(negedge clk);
    clr = 1'b0; s_valid = 1'b0;
    #1;
    checks++;
    if (bit_valid !== 1'b0) begin errors++; $display("FAIL clr_bit_valid: got %b expected 0", bit_valid); end
    checks++;
    if (fcs_o !== 16'h1EF0) begin errors++; $display("FAIL clr_fcs_kept: got %h expected 1ef0", fcs_o); end
    checks++;
    if (byte_cnt !== 16'd3) begin errors++; $display("FAIL clr_byte_cnt: got %0d expected 3", byte_cnt); end
    for (int c = 0; c < 40; c++) begin
      if (bit_valid !== 1'b0 || frame_done !== 1'b0) bad++;
      @(negedge clk);
      #1;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL clr_quiet: %0d cycles with activity expected 0", bad); end
    @(negedge clk);
    run_frame("after_clr", 9, 100, 0, 16'h31C3, 1'b0, 8'h00);
  endtask

  task automatic test_rst_in_fcs();
    int bits, cycles;
    bits = 0; cycles = 0;
    bit_en = 1'b1; s_valid = 1'b1; s_data = 8'h01; s_last = 1'b1;
    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0;
    while (bits < 12 && cycles < 200) begin
      #1;
      if (bit_valid === 1'b1) bits++;
      @(negedge clk);
      cycles++;
    end
    checks++;
    if (bit_valid !== 1'b1 || bit_last !== 1'b0) begin
      errors++; $display("FAIL rst_setup: bit_valid=%b bit_last=%b expected 1/0", bit_valid, bit_last);
    end
    rst = 1'b1; clr = 1'b1; s_valid = 1'b1; s_data = 8'hAA;
    @(negedge clk);
    rst = 1'b0; clr = 1'b0; s_valid = 1'b0; bit_en = 1'b0;
    #1;
    check_idle_outputs("rst_fcs", 16'h0000, 16'd0);
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; s_data = 8'h00; s_valid = 1'b0; s_last = 1'b0; bit_en = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    test_reset();
    @(negedge clk);
    test_check_string();
    test_single_bytes();
    test_random_en();
    test_back_to_back();
    test_clr();
    test_rst_in_fcs();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
